// File: rtl/stream_demux.sv
// Packet-level stream demultiplexer: routes whole packets from one input stream
// to one of NCH output channels through a single output register stage.
module stream_demux #(
   parameter int NCH    = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic [SEL_W-1:0]  in_sel,
   output logic [NCH-1:0]    out_valid,
   input  logic [NCH-1:0]    out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [15:0]       drop_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(NCH);

   state_t              state;
   state_t              state_nxt;
   logic [SEL_W-1:0]    lock_ch;
   logic                buf_valid;
   logic [DATA_W-1:0]   buf_data;
   logic [SEL_W-1:0]    buf_ch;
   logic                buf_last;

   logic                sel_bad;
   logic                drain;
   logic                accept;
   logic                route_acc;
   logic                drop_acc;
   logic [SEL_W-1:0]    route_ch;

   // Handshake: a beat transfers on a clk edge where valid && ready are both 1;
   // valid never waits on ready, and a buffered beat is held until taken.
   always_comb begin
      sel_bad   = 1'b0;
      drain     = 1'b0;
      in_ready  = 1'b0;
      accept    = 1'b0;
      route_acc = 1'b0;
      drop_acc  = 1'b0;
      route_ch  = lock_ch;
      state_nxt = state;

      sel_bad = ({1'b0, in_sel} >= NCH_L);
      for (int i = 0; i < NCH; i++) begin
         if (buf_ch == SEL_W'(i)) drain = buf_valid && out_ready[i];
      end

      // Discarded beats never touch the buffer, so they need no backpressure.
      if (state == DROP || (state == IDLE && sel_bad)) in_ready = 1'b1;
      else                                            in_ready = !buf_valid || drain;

      accept = in_valid && in_ready && !rst;

      case (state)
         IDLE: begin
            route_ch = in_sel;
            if (accept) begin
               if (sel_bad) begin
                  drop_acc  = 1'b1;
                  state_nxt = in_last ? IDLE : DROP;
               end else begin
                  route_acc = 1'b1;
                  state_nxt = in_last ? IDLE : BUSY;
               end
            end
         end
         BUSY: begin
            if (accept) begin
               route_acc = 1'b1;
               if (in_last) state_nxt = IDLE;
            end
         end
         DROP: begin
            if (accept && in_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lock_ch   <= '0;
         buf_valid <= 1'b0;
         buf_data  <= '0;
         buf_ch    <= '0;
         buf_last  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (route_acc && state == IDLE) lock_ch <= in_sel;
         if (route_acc) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
            buf_ch    <= route_ch;
            buf_last  <= in_last;
         end else if (drain) begin
            buf_valid <= 1'b0;
         end
         if (drop_acc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < NCH; i++) begin
         out_valid[i] = buf_valid && (buf_ch == SEL_W'(i));
      end
   end

   assign out_data = buf_data;
   assign out_last = buf_last;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing, backpressure
// and reset, and a 3-channel instance for out-of-range select handling.
module tb_stream_demux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-channel instance
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic [1:0] in_sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic [15:0] drop_cnt;

   // 3-channel instance
   logic       in_valid_3;
   logic       in_ready_3;
   logic [7:0] in_data_3;
   logic       in_last_3;
   logic [1:0] in_sel_3;
   logic [2:0] out_valid_3;
   logic [2:0] out_ready_3;
   logic [7:0] out_data_3;
   logic       out_last_3;
   logic [15:0] drop_cnt_3;

   int checks   = 0;
   int failures = 0;

   stream_demux #(.NCH(4), .DATA_W(8)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .drop_cnt  (drop_cnt)
   );

   stream_demux #(.NCH(3), .DATA_W(8)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_3),
      .in_ready  (in_ready_3),
      .in_data   (in_data_3),
      .in_last   (in_last_3),
      .in_sel    (in_sel_3),
      .out_valid (out_valid_3),
      .out_ready (out_ready_3),
      .out_data  (out_data_3),
      .out_last  (out_last_3),
      .drop_cnt  (drop_cnt_3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] sel, input logic [7:0] data, input logic last);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      in_last  = last;
   endtask

   task automatic beat_3(input logic [1:0] sel, input logic [7:0] data, input logic last);
      in_valid_3 = 1'b1;
      in_sel_3   = sel;
      in_data_3  = data;
      in_last_3  = last;
   endtask

   // Registered outputs of the 4-channel instance after the last edge.
   task automatic expect_out(input string tag, input logic [3:0] v, input logic [7:0] d,
                             input logic l);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      if (v != 4'b0000) begin
         check({tag, ".data"}, 32'(out_data), 32'(d));
         check({tag, ".last"}, 32'(out_last), 32'(l));
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_last     = 1'b0;
      in_sel      = '0;
      out_ready   = 4'b1111;
      in_valid_3  = 1'b0;
      in_data_3   = '0;
      in_last_3   = 1'b0;
      in_sel_3    = '0;
      out_ready_3 = 3'b111;

      // Reset state
      tick();
      tick();
      check("rst.out_valid", 32'(out_valid), 32'h0);
      check("rst.out_last",  32'(out_last),  32'h0);
      check("rst.out_data",  32'(out_data),  32'h0);
      check("rst.drop_cnt",  32'(drop_cnt),  32'h0);
      check("rst.out_valid_3", 32'(out_valid_3), 32'h0);
      rst = 1'b0;

      // 3-beat packet to channel 2
      tick();
      beat(2'd2, 8'h11, 1'b0);
      #1 check("p2.ready0", 32'(in_ready), 32'h1);
      tick();
      expect_out("p2.b0", 4'b0100, 8'h11, 1'b0);
      beat(2'd2, 8'h22, 1'b0);
      tick();
      expect_out("p2.b1", 4'b0100, 8'h22, 1'b0);
      beat(2'd2, 8'h33, 1'b1);
      tick();
      expect_out("p2.b2", 4'b0100, 8'h33, 1'b1);

      // Back-to-back packet to channel 1, select toggled mid-packet
      beat(2'd1, 8'h44, 1'b0);
      #1 check("p1.ready0", 32'(in_ready), 32'h1);
      tick();
      expect_out("p1.b0", 4'b0010, 8'h44, 1'b0);
      beat(2'd0, 8'h55, 1'b0);
      tick();
      expect_out("p1.b1", 4'b0010, 8'h55, 1'b0);
      beat(2'd0, 8'h66, 1'b1);
      tick();
      expect_out("p1.b2", 4'b0010, 8'h66, 1'b1);
      in_valid = 1'b0;
      tick();
      check("p1.idle", 32'(out_valid), 32'h0);

      // Channel 3 stalled; channel 0 ready must not drain it
      out_ready = 4'b0001;
      beat(2'd3, 8'hA1, 1'b0);
      #1 check("bp.ready_empty", 32'(in_ready), 32'h1);
      tick();
      expect_out("bp.first", 4'b1000, 8'hA1, 1'b0);
      beat(2'd3, 8'hA2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1 check("bp.ready_stall", 32'(in_ready), 32'h0);
         tick();
         expect_out("bp.hold", 4'b1000, 8'hA1, 1'b0);
      end
      out_ready = 4'b1000;
      #1 check("bp.ready_drain", 32'(in_ready), 32'h1);
      tick();
      expect_out("bp.second", 4'b1000, 8'hA2, 1'b0);
      beat(2'd3, 8'hA3, 1'b1);
      tick();
      expect_out("bp.third", 4'b1000, 8'hA3, 1'b1);
      in_valid  = 1'b0;
      out_ready = 4'b1111;
      tick();
      check("bp.idle", 32'(out_valid), 32'h0);

      // Single-beat packets rotating over all channels, one per cycle
      beat(2'd0, 8'hB0, 1'b1);
      tick();
      expect_out("rot.0", 4'b0001, 8'hB0, 1'b1);
      beat(2'd1, 8'hB1, 1'b1);
      #1 check("rot.ready1", 32'(in_ready), 32'h1);
      tick();
      expect_out("rot.1", 4'b0010, 8'hB1, 1'b1);
      beat(2'd2, 8'hB2, 1'b1);
      tick();
      expect_out("rot.2", 4'b0100, 8'hB2, 1'b1);
      beat(2'd3, 8'hB3, 1'b1);
      tick();
      expect_out("rot.3", 4'b1000, 8'hB3, 1'b1);
      in_valid = 1'b0;
      tick();
      check("rot.idle", 32'(out_valid), 32'h0);

      // 3-channel: 2-beat packet with select 3 is discarded
      beat_3(2'd3, 8'hC1, 1'b0);
      #1 check("drop.ready0", 32'(in_ready_3), 32'h1);
      tick();
      check("drop.valid0", 32'(out_valid_3), 32'h0);
      check("drop.cnt0",   32'(drop_cnt_3),  32'h1);
      beat_3(2'd1, 8'hC2, 1'b1);
      #1 check("drop.ready1", 32'(in_ready_3), 32'h1);
      tick();
      check("drop.valid1", 32'(out_valid_3), 32'h0);
      check("drop.cnt1",   32'(drop_cnt_3),  32'h1);
      beat_3(2'd0, 8'hC3, 1'b1);
      tick();
      check("drop.next_valid", 32'(out_valid_3), 32'h1);
      check("drop.next_data",  32'(out_data_3),  32'hC3);
      check("drop.next_last",  32'(out_last_3),  32'h1);

      // 3-channel: dropped beat while channel 0 is stalled leaves buffer intact
      out_ready_3 = 3'b000;
      beat_3(2'd3, 8'hC4, 1'b1);
      #1 check("dropst.ready", 32'(in_ready_3), 32'h1);
      tick();
      check("dropst.valid", 32'(out_valid_3), 32'h1);
      check("dropst.data",  32'(out_data_3),  32'hC3);
      check("dropst.cnt",   32'(drop_cnt_3),  32'h2);
      in_valid_3  = 1'b0;
      out_ready_3 = 3'b111;
      tick();
      check("dropst.drain", 32'(out_valid_3), 32'h0);

      // Reset on beat 2 of a 4-beat packet to channel 1
      beat(2'd1, 8'hD1, 1'b0);
      tick();
      expect_out("rstm.b0", 4'b0010, 8'hD1, 1'b0);
      beat(2'd1, 8'hD2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstm.valid", 32'(out_valid),  32'h0);
      check("rstm.data",  32'(out_data),   32'h0);
      check("rstm.cnt",   32'(drop_cnt),   32'h0);
      check("rstm.cnt_3", 32'(drop_cnt_3), 32'h0);
      beat(2'd2, 8'hE1, 1'b1);
      tick();
      expect_out("rstm.next", 4'b0100, 8'hE1, 1'b1);
      in_valid = 1'b0;
      tick();
      check("rstm.idle", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: NCH, default 4, number of output channels; legal range 2..16.
REQ-002 Parameter: DATA_W, default 8, beat data width in bits.
REQ-003 Parameter: SEL_W, derived as max(1, clog2(NCH)), select width; not user-overridable.
REQ-004 Clocking and reset shall be: one clock; reset is synchronous and active-high.
REQ-005 Ports shall be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready at clk edge.
- in_data  in  DATA_W  input beat payload.
- in_last  in  1  final beat of packet.
- in_sel  in  SEL_W  destination channel; sampled only on a packet's first beat.
- out_valid  out  NCH  per-channel valid, at most one bit set.
- out_ready  in  NCH  per-channel ready.
- out_data  out  DATA_W  payload, shared by all channels.
- out_last  out  1  final-beat flag, shared by all channels.
- drop_cnt  out  16  count of packets discarded for out-of-range select.

Function
REQ-006 Block shall route whole packets from one input stream to one of NCH output streams, holding the route for the entire packet.
REQ-007 Control FSM states shall be IDLE (awaiting first beat), BUSY (packet locked to a channel), DROP (discarding packet).
REQ-008 In IDLE, an accepted beat with in_sel < NCH shall latch lock_ch = in_sel; next state BUSY if in_last=0, else IDLE.
REQ-009 In IDLE, an accepted beat with in_sel >= NCH shall be discarded, increment drop_cnt; next state DROP if in_last=0, else IDLE.
REQ-010 In BUSY, in_sel shall be ignored; beats route to lock_ch; an accepted beat with in_last=1 returns to IDLE.
REQ-011 In DROP, in_ready shall be 1; accepted beats discarded; accepted in_last=1 returns to IDLE.
REQ-012 One output register stage (buf_valid, buf_data, buf_ch, buf_last) shall hold routed beats; latency input accept -> out_valid = exactly 1 cycle.
REQ-013 out_valid[i] = buf_valid && (buf_ch == i); out_data = buf_data; out_last = buf_last.
REQ-014 For routed beats, in_ready = !buf_valid || out_ready[buf_ch] (combinational pass-through; full throughput 1 beat/cycle when downstream ready).
REQ-015 In IDLE with in_sel >= NCH, in_ready shall be 1 regardless of buffer state.
REQ-016 Buffered beat shall be held stable (data, channel, last) until out_ready[buf_ch]=1; out_ready of other channels shall have no effect.
REQ-017 Simultaneous buffer drain and new routed accept shall replace buffer contents in the same cycle with buf_valid remaining 1.
REQ-018 Back-to-back packets to different channels shall incur no bubble: a new packet's first beat may be accepted the cycle after the prior last beat.
REQ-019 A dropped beat shall never load the buffer or disturb a buffered beat.
REQ-020 drop_cnt shall saturate at 16'hFFFF.
REQ-021 Outputs shall not depend on in_data, in_last or in_sel except via in_ready per REQ-014/015.

Reset
REQ-022 On rst=1 at a clk edge: state=IDLE, buf_valid=0, out_valid=0, out_last=0, out_data=0, lock_ch=0, drop_cnt=0.
REQ-023 Reset mid-packet shall abandon the packet and any buffered beat; the next accepted beat is treated as a first beat.
REQ-024 in_ready during rst=1 shall be don't-care; no beat is accepted while rst=1.

Verification
REQ-025 NCH=4, DATA_W=8: 3-beat packet in_sel=2, data 0x11,0x22,0x33, all out_ready=1 -> out_valid=4'b0100 for 3 consecutive cycles starting 1 cycle after first accept, last on 0x33.
REQ-026 Mid-packet in_sel toggled to 0 on beats 2-3 of a packet started with in_sel=1 -> all beats appear on channel 1 only.
REQ-027 out_ready[3]=0 for 5 cycles with packet to channel 3 -> in_ready=0 after one beat buffered, out_data stable, no beat lost or duplicated; out_ready[0]=1 changes nothing.
REQ-028 NCH=3: 2-beat packet in_sel=3 -> in_ready=1 both beats, out_valid=0 throughout, drop_cnt 0->1; following packet in_sel=0 routes normally.
REQ-029 rst asserted on beat 2 of a 4-beat packet to channel 1 -> out_valid=0 next cycle, drop_cnt=0; next packet in_sel=2 routes to channel 2.
REQ-030 Single-beat packets alternating in_sel 0,1,2,3 every cycle, all ready -> one beat per cycle, out_valid 0001,0010,0100,1000, no bubbles.
